// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// The shift-op encoding matches the select field of the 1-bit shifter.
package shift_seq_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;

  // Bit that leaves the word on one step of the given op.
  function automatic logic shift_out_bit(input shift_op_t op, input logic [DATA_W-1:0] v);
    logic b;
    b = (op == SH_LSL) ? v[DATA_W-1] : v[0];
    return b;
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational 1-bit shift step: 00 pass, 01 LSL1, 10 LSR1, 11 ASR1.
// Zero fill for logical shifts, sign replication for ASR.
module shifter
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] sout
);

  always_comb begin
    sout = in;
    case (shift)
      SH_LSL:  sout = {in[DATA_W-2:0], 1'b0};
      SH_LSR:  sout = {1'b0, in[DATA_W-1:1]};
      SH_ASR:  sout = {in[DATA_W-1], in[DATA_W-1:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates the 1-bit shifter in_amt times
// behind a valid/ready request and a valid/ready result interface.
//
// state | meaning
// IDLE  | ready for a request; result (if any) already consumed
// SHIFT | one shifter step per cycle, cnt holds steps remaining
// DONE  | result presented, waiting for out_ready
module shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_zero,
  output logic              busy
);
  import shift_seq_pkg::*;

  // The step unit is hard-wired to 16 bits; refuse any other width.
  if (DATA_W != shift_seq_pkg::DATA_W) begin : g_width_check
    $error("shift_sequencer: DATA_W must be 16");
  end

  seq_state_t        state, state_nxt;
  logic [DATA_W-1:0] work;
  logic [AMT_W-1:0]  cnt;
  shift_op_t         op_q;
  logic              carry;

  logic [DATA_W-1:0] sout;
  logic [1:0]        shift_sel;
  logic              accept;
  logic              skip_shift;

  assign accept     = (state == IDLE) && in_valid && !flush;
  assign skip_shift = (in_amt == '0) || (in_op == SH_NONE);
  assign shift_sel  = (state == SHIFT) ? op_q : SH_NONE;

  shifter u_shifter (
    .in    (work),
    .shift (shift_sel),
    .sout  (sout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = skip_shift ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // cnt only decrements in SHIFT, where it is always >= 1, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      cnt   <= '0;
      op_q  <= SH_NONE;
      carry <= 1'b0;
    end else if (accept) begin
      work  <= in_data;
      cnt   <= in_amt;
      op_q  <= shift_op_t'(in_op);
      carry <= 1'b0;
    end else if (state == SHIFT && !flush) begin
      work  <= sout;
      cnt   <= cnt - AMT_W'(1);
      carry <= shift_out_bit(op_q, work);
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;
  assign out_carry = carry;
  assign out_zero  = (work == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a vector table of single operations
// plus hand-written reset, backpressure and flush sequences.
module tb_shift_sequencer;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_amt;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_carry;
  logic          out_zero;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_sequencer #(.DATA_W(DW), .AMT_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_data;
    logic          exp_carry;
    logic          exp_zero;
    int            exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request; returns after the accept edge (+1).
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] amt, input logic [DW-1:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = amt;
    in_data  = data;
    check("in_ready_before_req", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'h5A5A;
    in_op    = 2'b01;
    in_amt   = 4'd9;
  endtask

  // Counts edges from the accept edge until out_valid; bounded.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    out_ready = 1'b1;
    issue(v.op, v.amt, v.data);
    wait_result(lat);
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_data"},  32'(out_data),  32'(v.exp_data));
    check({tag, "_carry"}, 32'(out_carry), 32'(v.exp_carry));
    check({tag, "_zero"},  32'(out_zero),  32'(v.exp_zero));
    @(posedge clk);
    #1;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen_valid;

    //            op     amt   data      exp_data  c     z     lat
    vecs.push_back('{2'b01, 4'd4,  16'h0001, 16'h0010, 1'b0, 1'b0, 5});
    vecs.push_back('{2'b11, 4'd3,  16'h8000, 16'hF000, 1'b0, 1'b0, 4});
    vecs.push_back('{2'b10, 4'd1,  16'h00F1, 16'h0078, 1'b1, 1'b0, 2});
    vecs.push_back('{2'b01, 4'd0,  16'hABCD, 16'hABCD, 1'b0, 1'b0, 1});
    vecs.push_back('{2'b00, 4'd7,  16'hABCD, 16'hABCD, 1'b0, 1'b0, 1});
    vecs.push_back('{2'b01, 4'd15, 16'h8000, 16'h0000, 1'b0, 1'b1, 16});
    vecs.push_back('{2'b10, 4'd15, 16'h0001, 16'h0000, 1'b0, 1'b1, 16});
    vecs.push_back('{2'b11, 4'd15, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16});
    vecs.push_back('{2'b11, 4'd15, 16'h4000, 16'h0000, 1'b1, 1'b1, 16});
    vecs.push_back('{2'b01, 4'd4,  16'h1234, 16'h2340, 1'b1, 1'b0, 5});
    vecs.push_back('{2'b10, 4'd4,  16'h1234, 16'h0123, 1'b0, 1'b0, 5});
    vecs.push_back('{2'b11, 4'd4,  16'hF0F0, 16'hFF0F, 1'b0, 1'b0, 5});
    vecs.push_back('{2'b01, 4'd15, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 16});
    vecs.push_back('{2'b11, 4'd1,  16'h7FFF, 16'h3FFF, 1'b1, 1'b0, 2});
    vecs.push_back('{2'b11, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_amt    = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Async reset in the middle of LSL 0x1234 by 8, after 3 steps.
    out_ready = 1'b1;
    issue(2'b01, 4'd8, 16'h1234);
    repeat (3) @(posedge clk);
    #2;
    check("midshift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_out_carry", 32'(out_carry), 32'd0);
    check("arst_out_zero",  32'(out_zero),  32'd1);
    check("arst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release_in_ready", 32'(in_ready), 32'd1);
    check("arst_release_valid",    32'(out_valid), 32'd0);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(2'b01, 4'd1, 16'h8000);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd2);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_amt   = 4'd2;
    in_data  = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_%0d", k),    32'(out_valid), 32'd1);
      check($sformatf("bp_data_%0d", k),     32'(out_data),  32'h0000);
      check($sformatf("bp_carry_%0d", k),    32'(out_carry), 32'd1);
      check($sformatf("bp_zero_%0d", k),     32'(out_zero),  32'd1);
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(in_ready),  32'd1);
    check("bp_release_valid",    32'(out_valid), 32'd0);
    check("bp_ignored_req_data", 32'(out_data),  32'h0000);

    // Flush on the 4th step of LSR 0xFFFF by 10.
    seen_valid = 1'b0;
    issue(2'b10, 4'd10, 16'hFFFF);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy",     32'(busy),      32'd0);
    check("flush_in_ready", 32'(in_ready),  32'd1);
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);

    // Flush together with a request in IDLE drops the request.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_amt   = 4'd0;
    in_data  = 16'h1357;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flushreq_busy",      32'(busy),      32'd0);
    check("flushreq_in_ready",  32'(in_ready),  32'd1);
    check("flushreq_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("flushreq_busy_later", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
